apb_i2c_regif_fifo: RTL
=======================

// Module: apb_i2c_regif_fifo
// PURPOSE
// - Parametrised APB slave register interface for the I2C core; successor to the fixed-width register bridge.
// - Integrates TX and RX FIFOs (depth FIFO_DEPTH), readable CONFIG/TIMEOUT/STATUS registers and maskable interrupts.
// - Latches a sticky error flag. Optionally inserts APB wait states on FIFO full/empty.
// - Sits between the APB interconnect and the I2C core's byte engine.
// PARAMETERS
// - DATA_W      32  APB/FIFO data width
// - FIFO_DEPTH  8   entries per FIFO; power of 2, >=2
// - CFG_W       14  width of the CONFIG and TIMEOUT registers
// - ADDR_W      8   PADDR width, byte address
// PORTS
// - PCLK          in   1        clock
// - PRESETn       in   1        asynchronous, active-low reset
// - PSELx         in   1        APB select
// - PENABLE       in   1        APB access phase
// - PWRITE        in   1        1 = write
// - PADDR         in   ADDR_W   byte address
// - PWDATA        in   DATA_W   write data
// - PRDATA        out  DATA_W   read data
// - PREADY        out  1        transfer complete
// - PSLVERR       out  1        transfer error
// - TX_RD_EN      in   1        core pops the TX FIFO
// - TX_DATA       out  DATA_W   TX FIFO head (show-ahead)
// - RX_WR_EN      in   1        core pushes the RX FIFO
// - RX_DATA_IN    in   DATA_W   data pushed into RX
// - ERROR         in   1        core error pulse/level
// - I2C_CONFIG    out  CFG_W    CONFIG register
// - I2C_TIMEOUT   out  CFG_W    TIMEOUT register
// - TX_EMPTY      out  1        TX FIFO empty
// - RX_FULL       out  1        RX FIFO full
// - INT_TX        out  1        interrupt: TX empty
// - INT_RX        out  1        interrupt: RX has data
// BEHAVIOUR
// - Reset (async, PRESETn=0):
//   - all registers 0; both FIFOs empty, pointers 0
//   - TX_EMPTY=1, RX_FULL=0, INT_TX=INT_RX=0, PSLVERR=0, PREADY=0
// - Register map:
//   - 0x00 TXDATA W: push
//   - 0x04 RXDATA R: pop
//   - 0x08 CONFIG R/W
//   - 0x0C TIMEOUT R/W
//   - 0x10 STATUS R/W1C: [0]tx_empty [1]tx_full [2]rx_empty [3]rx_full [4]err (W1C) [5]rx_ovf (W1C)
//   - 0x14 IRQ_EN R/W: [0]tx [1]rx
// - Transfer protocol:
//   - A transfer completes on the posedge where PSELx&PENABLE&PREADY; state changes only then.
//   - PREADY is combinational, asserted only in the access phase.
//   - PRDATA = selected register/FIFO head while PSELx&~PWRITE, else 0; unused upper bits read 0.
//   - Writes to CFG_W registers take PWDATA[CFG_W-1:0].
//   - Unmapped address: PREADY=1, PSLVERR=1, no state change, PRDATA=0.
// - FIFOs:
//   - Counters are log2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.
//   - Full/empty decode from the registered count.
//   - Push+pop in the same cycle on a non-empty, non-full FIFO: count unchanged.
//   - Push when full is blocked even if a pop occurs in the same cycle.
//   - Core TX_RD_EN on empty: ignored.
//   - Core RX_WR_EN on full: data dropped, rx_ovf set.
// - Error: ERROR=1 in any cycle sets err; a W1C on the same cycle loses to the set.
// - Interrupts (level, combinational from registered state):
//   - INT_TX = tx_empty & IRQ_EN[0]
//   - INT_RX = ~rx_empty & IRQ_EN[1]
// CONFIGURATION
// - APB_I2C_WAIT_STATE_EN defined:
//   - Write TXDATA while tx_full: PREADY=0 until a TX slot is free, then completes with PSLVERR=0.
//   - Read RXDATA while rx_empty: PREADY=0 until data arrives, then completes with PSLVERR=0.
//   - Dropping PSELx mid-wait aborts the transfer with no state change.
// - APB_I2C_WAIT_STATE_EN undefined: both cases complete immediately with PREADY=1, PSLVERR=1, FIFO unchanged, PRDATA=0.
// TESTING
// 1. Reset mid-transfer -> all outputs at reset values asynchronously; STATUS reads 0x05.
// 2. Write 0x3FFF to 0x08 and 0x1234 to 0x0C -> I2C_CONFIG=0x3FFF, I2C_TIMEOUT=0x1234; readback matches; PSLVERR=0.
// 3. 9 TXDATA writes 0x10..0x18, depth 8, macro off -> 9th write PSLVERR=1; TX_DATA=0x10; 8 TX_RD_EN pops -> 0x10..0x17, TX_EMPTY=1.
// 4. Same 9th write with macro on, core pops 3 cycles later -> PREADY low 3 cycles, then 0x18 accepted.
// 5. RX_WR_EN 9x with 0xA0..0xA8 -> rx_ovf=1, RX_FULL=1; APB reads return 0xA0..0xA7; W1C 0x20 clears rx_ovf.
// 6. IRQ_EN=0x3, ERROR pulse -> INT_TX=1 when empty, INT_RX=1 after one RX push; err=1 until W1C 0x10; read 0x20 -> PSLVERR=1.

Source files
------------

// File: rtl/apb_i2c_regif_fifo_if.sv
// APB bus bundle between the interconnect (master) and the I2C register block (slave).
interface apb_i2c_regif_fifo_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              PSELx;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
                    input  PRDATA, PREADY, PSLVERR);
    modport slave  (input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
                    output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_i2c_regif_fifo.sv
// APB register interface for the I2C core: TX/RX FIFOs, CONFIG/TIMEOUT, STATUS (W1C) and IRQ enables.
// Define APB_I2C_WAIT_STATE_EN to stall TXDATA-full writes / RXDATA-empty reads instead of erroring them.
module apb_i2c_regif_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CFG_W      = 14,
    parameter int ADDR_W     = 8
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    apb_i2c_regif_fifo_if.slave apb,
    input  logic                TX_RD_EN,
    output logic [DATA_W-1:0]   TX_DATA,
    input  logic                RX_WR_EN,
    input  logic [DATA_W-1:0]   RX_DATA_IN,
    input  logic                ERROR,
    output logic [CFG_W-1:0]    I2C_CONFIG,
    output logic [CFG_W-1:0]    I2C_TIMEOUT,
    output logic                TX_EMPTY,
    output logic                RX_FULL,
    output logic                INT_TX,
    output logic                INT_RX
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]     FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] A_TXDATA  = ADDR_W'(8'h00);
    localparam logic [ADDR_W-1:0] A_RXDATA  = ADDR_W'(8'h04);
    localparam logic [ADDR_W-1:0] A_CONFIG  = ADDR_W'(8'h08);
    localparam logic [ADDR_W-1:0] A_TIMEOUT = ADDR_W'(8'h0C);
    localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(8'h10);
    localparam logic [ADDR_W-1:0] A_IRQ_EN  = ADDR_W'(8'h14);

    typedef logic [DATA_W-1:0] word_t;

    word_t            tx_mem_q [FIFO_DEPTH];
    word_t            tx_mem_d [FIFO_DEPTH];
    word_t            rx_mem_q [FIFO_DEPTH];
    word_t            rx_mem_d [FIFO_DEPTH];
    logic [AW-1:0]    tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [AW-1:0]    rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [CW-1:0]    tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [CFG_W-1:0] config_q, config_d, timeout_q, timeout_d;
    logic [1:0]       irq_en_q, irq_en_d;
    logic             err_q, err_d, rx_ovf_q, rx_ovf_d;

    logic  tx_empty, tx_full, rx_empty, rx_full;
    logic  sel_tx, sel_rx, sel_cfg, sel_to, sel_st, sel_irq, mapped;
    logic  access, tx_block, rx_block, stall, slv_err, xfer_ok, wr_ok, rd_ok;
    logic  tx_push, tx_pop, rx_push, rx_pop, rx_drop;
    word_t status_w;

    always_comb begin
        tx_empty = (tx_cnt_q == '0);
        tx_full  = (tx_cnt_q == FULL_CNT);
        rx_empty = (rx_cnt_q == '0);
        rx_full  = (rx_cnt_q == FULL_CNT);

        sel_tx  = (apb.PADDR == A_TXDATA);
        sel_rx  = (apb.PADDR == A_RXDATA);
        sel_cfg = (apb.PADDR == A_CONFIG);
        sel_to  = (apb.PADDR == A_TIMEOUT);
        sel_st  = (apb.PADDR == A_STATUS);
        sel_irq = (apb.PADDR == A_IRQ_EN);
        mapped  = sel_tx | sel_rx | sel_cfg | sel_to | sel_st | sel_irq;

        access   = apb.PSELx & apb.PENABLE;
        tx_block = sel_tx & apb.PWRITE & tx_full;
        rx_block = sel_rx & ~apb.PWRITE & rx_empty;
`ifdef APB_I2C_WAIT_STATE_EN
        stall   = tx_block | rx_block;
        slv_err = ~mapped;
`else
        stall   = 1'b0;
        slv_err = ~mapped | tx_block | rx_block;
`endif
        // Bus outputs are forced quiet while reset is held, even mid-transfer.
        apb.PREADY  = PRESETn & access & ~stall;
        apb.PSLVERR = apb.PREADY & slv_err;
        xfer_ok     = apb.PREADY & ~slv_err;
        wr_ok       = xfer_ok & apb.PWRITE;
        rd_ok       = xfer_ok & ~apb.PWRITE;

        status_w = DATA_W'({rx_ovf_q, err_q, rx_full, rx_empty, tx_full, tx_empty});

        apb.PRDATA = '0;
        if (PRESETn && apb.PSELx && !apb.PWRITE && !slv_err) begin
            if (sel_rx && !rx_empty) apb.PRDATA = rx_mem_q[rx_rptr_q];
            if (sel_cfg)             apb.PRDATA = DATA_W'(config_q);
            if (sel_to)              apb.PRDATA = DATA_W'(timeout_q);
            if (sel_st)              apb.PRDATA = status_w;
            if (sel_irq)             apb.PRDATA = DATA_W'(irq_en_q);
        end
    end

    always_comb begin
        tx_mem_d  = tx_mem_q;
        rx_mem_d  = rx_mem_q;
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        config_d  = config_q;
        timeout_d = timeout_q;
        irq_en_d  = irq_en_q;

        // Full/empty come from the registered count, so a same-cycle pop never frees a slot for a push.
        tx_push = wr_ok & sel_tx & ~tx_full;
        tx_pop  = TX_RD_EN & ~tx_empty;
        rx_push = RX_WR_EN & ~rx_full;
        rx_drop = RX_WR_EN & rx_full;
        rx_pop  = rd_ok & sel_rx & ~rx_empty;

        if (tx_push) begin
            tx_mem_d[tx_wptr_q] = apb.PWDATA;
            tx_wptr_d           = tx_wptr_q + AW'(1);
        end
        if (tx_pop)  tx_rptr_d = tx_rptr_q + AW'(1);
        if (rx_push) begin
            rx_mem_d[rx_wptr_q] = RX_DATA_IN;
            rx_wptr_d           = rx_wptr_q + AW'(1);
        end
        if (rx_pop)  rx_rptr_d = rx_rptr_q + AW'(1);

        tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);

        if (wr_ok && sel_cfg) config_d  = apb.PWDATA[CFG_W-1:0];
        if (wr_ok && sel_to)  timeout_d = apb.PWDATA[CFG_W-1:0];
        if (wr_ok && sel_irq) irq_en_d  = apb.PWDATA[1:0];

        // A set in the same cycle as the W1C wins.
        err_d    = ERROR   | (err_q    & ~(wr_ok & sel_st & apb.PWDATA[4]));
        rx_ovf_d = rx_drop | (rx_ovf_q & ~(wr_ok & sel_st & apb.PWDATA[5]));
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                tx_mem_q[i] <= '0;
                rx_mem_q[i] <= '0;
            end
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            config_q  <= '0;
            timeout_q <= '0;
            irq_en_q  <= '0;
            err_q     <= 1'b0;
            rx_ovf_q  <= 1'b0;
        end else begin
            tx_mem_q  <= tx_mem_d;
            rx_mem_q  <= rx_mem_d;
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            config_q  <= config_d;
            timeout_q <= timeout_d;
            irq_en_q  <= irq_en_d;
            err_q     <= err_d;
            rx_ovf_q  <= rx_ovf_d;
        end
    end

    assign TX_DATA     = tx_mem_q[tx_rptr_q];
    assign I2C_CONFIG  = config_q;
    assign I2C_TIMEOUT = timeout_q;
    assign TX_EMPTY    = tx_empty;
    assign RX_FULL     = rx_full;
    assign INT_TX      = tx_empty & irq_en_q[0];
    assign INT_RX      = ~rx_empty & irq_en_q[1];
endmodule
